// File: rtl/led_frame_scheduler.sv
`timescale 1ns/1ps
// led_frame_scheduler
//   Double-buffered 16x16 red/green frame store plus scan scheduler for the
//   LED matrix driver. A producer edits the back buffer row by row, then
//   requests a commit. The back buffer is copied to the displayed front
//   buffer only when the driver's row scan wraps, so a torn frame is never
//   shown. The block also generates the driver's EnableCount pulse and keeps
//   a mirror of the driver's scan counter.
//
// Ports
//   CLK, RST     clock, synchronous active-high reset
//   WrEn/WrRow   write WrRed/WrGrn into back-buffer row WrRow (ignored while Busy)
//   Commit       request back->front copy at next frame boundary (ignored while Busy)
//   Busy         commit pending
//   SwapDone     one-cycle pulse, the cycle after the front buffer changed
//   EnableCount  scan-advance pulse to the driver
//   FrameStart   EnableCount while the mirrored scan counter is 0
//   RedPixels    front buffer red,   [row][col]
//   GrnPixels    front buffer green, [row][col]

// One row of storage: back copy written by the producer, front copy loaded on swap.
module led_row_store #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         wr_en,
  input  logic [W-1:0] wr_red,
  input  logic [W-1:0] wr_grn,
  input  logic         swap,
  output logic [W-1:0] red,
  output logic [W-1:0] grn
);
  logic [W-1:0] back_red, back_grn;

  // wr_en and swap are mutually exclusive: writes need !Busy, swaps need Busy.
  always_ff @(posedge CLK) begin
    if (RST) begin
      back_red <= '0;
      back_grn <= '0;
      red      <= '0;
      grn      <= '0;
    end else begin
      if (wr_en) begin
        back_red <= wr_red;
        back_grn <= wr_grn;
      end
      if (swap) begin
        red <= back_red;
        grn <= back_grn;
      end
    end
  end
endmodule

module led_frame_scheduler #(
  parameter int FREQDIV     = 15,
  parameter int TICK_PERIOD = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WrEn,
  input  logic [3:0]        WrRow,
  input  logic [15:0]       WrRed,
  input  logic [15:0]       WrGrn,
  input  logic              Commit,
  output logic              Busy,
  output logic              SwapDone,
  output logic              EnableCount,
  output logic              FrameStart,
  output logic [15:0][15:0] RedPixels,
  output logic [15:0][15:0] GrnPixels
);
  localparam int NUM_ROWS = 16;
  localparam int ROW_W    = 16;
  localparam int TICK_W   = $clog2(TICK_PERIOD) + 1;
  localparam int SCAN_W   = FREQDIV + 4;
  localparam int STAGES   = 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_PERIOD - 1);

  typedef struct packed {
    logic [3:0]       row;
    logic [ROW_W-1:0] red;
    logic [ROW_W-1:0] grn;
  } wr_req_t;

  typedef enum logic {IDLE, PENDING} state_t;

  state_t            state, state_nxt;
  wr_req_t           wr_req;
  logic [TICK_W-1:0] tick_cnt;
  logic [SCAN_W-1:0] scan_cnt;
  logic              frame_end;
  logic              wr_ok;
  logic              swap;
  logic [STAGES:0]   vld_pipe;

  assign wr_req = '{row: WrRow, red: WrRed, grn: WrGrn};

  // Tick divider and mirrored scan counter; both restart on RST together with
  // the driver so the mirror stays in lockstep.
  always_ff @(posedge CLK) begin
    if (RST) begin
      tick_cnt <= '0;
      scan_cnt <= '0;
    end else begin
      tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TICK_W'(1);
      if (EnableCount) scan_cnt <= scan_cnt + SCAN_W'(1);
    end
  end

  assign EnableCount = !RST && (tick_cnt == TICK_LAST);
  assign FrameStart  = EnableCount && (scan_cnt == '0);
  assign frame_end   = EnableCount && (&scan_cnt);

  // Commit FSM: state register
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Commit FSM: next state. A commit in the FrameEnd cycle while idle only
  // becomes pending; its swap waits for the next FrameEnd.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Commit)    state_nxt = PENDING;
      PENDING: if (frame_end) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Commit FSM: outputs
  always_comb begin
    Busy  = (state == PENDING);
    wr_ok = WrEn && (state == IDLE);
    swap  = (state == PENDING) && frame_end;
  end

  // Swap event delayed so SwapDone lands the cycle after the new image is visible.
  always_ff @(posedge CLK) begin
    if (RST) vld_pipe <= '0;
    else     vld_pipe <= {vld_pipe[STAGES-1:0], swap};
  end

  assign SwapDone = vld_pipe[STAGES];

  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
    led_row_store #(.W(ROW_W)) u_row (
      .CLK    (CLK),
      .RST    (RST),
      .wr_en  (wr_ok && (wr_req.row == 4'(r))),
      .wr_red (wr_req.red),
      .wr_grn (wr_req.grn),
      .swap   (swap),
      .red    (RedPixels[r]),
      .grn    (GrnPixels[r])
    );
  end
endmodule

// File: doc/led_frame_scheduler.md
Name: led_frame_scheduler

Overview:
Double-buffered frame store and scan scheduler feeding the 16x16 red/green LED matrix driver. A producer, such as the Game-of-Life engine, edits a back buffer row by row and then requests a commit. The block copies the back buffer to the displayed front buffer only at a scan-frame boundary, so a partial frame is never shown. It also generates the driver's EnableCount pulse and tracks the driver's row scan internally.

Parameters:
FREQDIV, 15, must equal the driver's FREQDIV; each row is held for 2^FREQDIV EnableCount pulses.
TICK_PERIOD, 1, CLK cycles per EnableCount pulse (>=1).

Ports:
CLK  in  1  system clock
RST  in  1  reset, synchronous, active-high
WrEn  in  1  write WrRed/WrGrn into back-buffer row WrRow
WrRow  in  4  back-buffer row index
WrRed  in  16  red row data, bit i = column i
WrGrn  in  16  green row data, bit i = column i
Commit  in  1  request copy of back buffer to front at next frame boundary
Busy  out  1  commit pending; writes and commits ignored
SwapDone  out  1  one-cycle pulse, cycle after front-buffer update
EnableCount  out  1  scan-advance pulse to driver
FrameStart  out  1  high in cycle where mirrored scan counter == 0 and EnableCount==1
RedPixels  out  16x16  front buffer red, [row][col]
GrnPixels  out  16x16  front buffer green, [row][col]

Behaviour:
- Reset RST, synchronous, active-high; clock CLK. All sequential state updates on posedge CLK.
- Reset values: front/back buffers all 0; TickCnt=0; ScanCnt=0; Busy=0; SwapDone=0; EnableCount=0 while RST is high.
- TickCnt: width clog2(TICK_PERIOD)+1. Wraps to 0 at TICK_PERIOD-1, else increments.
- EnableCount = !RST && (TickCnt == TICK_PERIOD-1). It is combinational from registers. With TICK_PERIOD=1 it is continuously high outside reset.
- ScanCnt: FREQDIV+4 bits. Increments (modulo) on each EnableCount and mirrors the driver's counter. Both are reset on the same RST.
- FrameEnd = EnableCount && ScanCnt == all-ones. Frame length = 16*2^FREQDIV*TICK_PERIOD cycles.
- Write: if WrEn && !Busy, back[WrRow] <= {WrRed, WrGrn} at the edge. WrEn while Busy is dropped silently. No write to front except via swap.
- Commit: if Commit && !Busy, Busy <= 1 at the edge. Commit while Busy is ignored.
- Swap: if Busy && FrameEnd, front <= back (full 512-bit copy; back retained, so incremental edits are supported) and Busy <= 0 on the same edge. The new image therefore appears exactly when the driver's counter wraps to row 0. SwapDone=1 the following cycle only.
- Simultaneous WrEn+Commit while idle: the write lands in back and is included in the committed frame.
- Commit asserted in the FrameEnd cycle while idle: becomes pending and swaps at the next FrameEnd, not the current one.
- WrEn in the swap cycle (Busy still 1): dropped.
- RST mid-pending: pending commit discarded, both buffers cleared, Busy=0, no SwapDone.
- Outputs RedPixels/GrnPixels are registered front-buffer contents and change only on swap or reset.

Test Plan:
1. FREQDIV=0, TICK_PERIOD=2; hold RST 2 cycles, release -> all pixels 0, Busy=0; EnableCount first high 2nd cycle after release, then every 2 cycles; FrameStart every 32 cycles.
2. Write WrRow=3, WrRed=16'h00FF, WrGrn=16'hF000, then Commit -> Busy=1; RedPixels[3] stays 0 until the FrameEnd edge, then RedPixels[3]==16'h00FF, GrnPixels[3]==16'hF000; Busy=0 on that edge, SwapDone pulses one cycle later.
3. While Busy, WrEn row 5 with WrRed=16'hFFFF, plus a second Commit -> after swap RedPixels[5]==0; only one SwapDone pulse.
4. Commit asserted in the exact FrameEnd cycle while idle -> no swap at that edge; swap at the following FrameEnd, 32 cycles later.
5. WrEn row 7 and Commit in the same idle cycle -> after swap RedPixels[7] equals the written data.
6. Commit, then RST asserted before FrameEnd -> Busy=0, all pixels 0, SwapDone never pulses; ScanCnt restarts and FrameStart recurs 32 cycles after release.
